if_prefetch_queue: RTL



---
 rtl/if_prefetch_queue_pkg.sv | 19 +
 rtl/if_prefetch_queue_if.sv | 31 +++
 rtl/if_prefetch_queue_fetch_fifo.sv | 52 +++++
 rtl/if_prefetch_queue.sv | 121 ++++++++++++
 4 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// Shared types for the instruction-fetch prefetch queue: fetch FSM states and
// the {pc, inst} entry layout at the default 32-bit widths.
package if_pkg;

  localparam int unsigned IF_ADDR_W = 32;
  localparam int unsigned IF_INST_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bus: ID-stage control, instruction-memory handshake and head entry.
interface if_prefetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 3
);

  logic              freeze;
  logic              flush;
  logic              Branch_taken;
  logic [ADDR_W-1:0] branchAddr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [ADDR_W-1:0] PC;
  logic [INST_W-1:0] Instruction;
  logic [CNT_W-1:0]  count;

  modport master (
    input  freeze, flush, Branch_taken, branchAddr, imem_ack, imem_rdata,
    output imem_req, imem_addr, inst_valid, PC, Instruction, count
  );

  modport slave (
    output freeze, flush, Branch_taken, branchAddr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, inst_valid, PC, Instruction, count
  );

endinterface

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// Power-of-two FIFO with synchronous clear; head is the oldest stored entry.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!i_clr && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch stage: issues sequential instruction fetches into a prefetch queue,
// handles stall, flush and branch redirect with stale-response dropping.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic              w_clr;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_cnt_nxt;
  entry_t            w_push_ent;
  entry_t            w_head;

  assign w_valid    = (w_count != '0);
  assign w_clr      = bus.Branch_taken | bus.flush;
  assign w_pop      = w_valid & ~w_clr & ~bus.freeze;
  assign w_push     = (r_state == WAIT) & bus.imem_ack & ~w_clr;
  assign w_cnt_nxt  = w_clr ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));
  assign w_pc_inc   = r_fetch_pc + ADDR_W'(PC_STEP);
  assign w_push_ent = {r_addr, bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_ent),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Issue only when the queue can absorb the response; branch overrides all.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_nxt      = 1'b0;
    w_addr_nxt     = r_addr;
    case (r_state)
      IDLE: begin
        if (!bus.Branch_taken && (w_count < CNT_W'(DEPTH))) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.Branch_taken) begin
          w_state_nxt = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          w_fetch_pc_nxt = w_pc_inc;
          if (w_cnt_nxt < CNT_W'(DEPTH)) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_pc_inc;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.imem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.Branch_taken) w_fetch_pc_nxt = bus.branchAddr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.inst_valid  = w_valid;
  assign bus.PC          = w_valid ? w_head.pc : '0;
  assign bus.Instruction = w_valid ? w_head.inst : '0;
  assign bus.count       = w_count;

endmodule
